debounce_scheduler: RTL and testbench

//   Time-multiplexed debounce controller for the game's button inputs.
//   One shared shift/compare datapath is scheduled round-robin over NUM_BTN

---
 rtl/debounce_scheduler.sv | 79 +++++++
 tb/tb_debounce_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin shared debouncer over NUM_BTN synced buttons (clk, reset, buttons -> debounced, scan_busy, scan_done, pressed, released; DEBOUNCE_EDGE_EN builds edge pulses)
module debounce_scheduler #(
  parameter int NUM_BTN  = 4,
  parameter int HIST_LEN = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [NUM_BTN-1:0] debounced,
  output logic               scan_busy,
  output logic               scan_done,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] released
);
  localparam int CW = NUM_BTN > 1 ? $clog2(NUM_BTN) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST_CNT = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_BTN - 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_next;
  logic [PW-1:0] cnt;
  logic [CW-1:0] ch;
  logic [NUM_BTN-1:0] sync_meta, sync;
  logic [HIST_LEN-1:0] hist [NUM_BTN];
  logic [HIST_LEN-1:0] new_hist;
  logic tick, last, all_one, all_zero;
  assign tick = cnt == LAST_CNT;
  assign last = ch == LAST_CH;
  assign new_hist = {hist[ch][HIST_LEN-2:0], sync[ch]};
  assign all_one = &new_hist;
  assign all_zero = ~|new_hist;
  assign scan_busy = state != IDLE;
  assign scan_done = state == DONE;
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (tick ? SCAN : IDLE) : state == SCAN ? (last ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
      sync_meta <= '0;
      sync <= '0;
      debounced <= '0;
      for (int i = 0; i < NUM_BTN; i++) hist[i] <= '0;
    end else begin
      state <= state_next;
      cnt <= tick ? '0 : cnt + PW'(1);
      sync_meta <= buttons;
      sync <= sync_meta;
      if (state == SCAN) begin
        hist[ch] <= new_hist;
        if (all_one) debounced[ch] <= 1'b1;
        else if (all_zero) debounced[ch] <= 1'b0;
        ch <= last ? ch : ch + CW'(1);
      end else if (state == DONE) ch <= '0;
    end
  end
`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pressed <= '0;
      released <= '0;
    end else begin
      pressed <= '0;
      released <= '0;
      if (state == SCAN) begin
        pressed[ch] <= all_one & ~debounced[ch];
        released[ch] <= all_zero & debounced[ch];
      end
    end
  end
`else
  assign pressed = '0;
  assign released = '0;
`endif
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed table-driven bench for debounce_scheduler
module tb_debounce_scheduler;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] buttons = 4'h0;
  logic [3:0] debounced, pressed, released;
  logic scan_busy, scan_done;
  int checks = 0;
  int errors = 0;
  int press_cnt [4] = '{default: 0};
  int rel_cnt [4] = '{default: 0};
  int multi = 0;
  int ovr = 0;
  typedef struct {
    logic [3:0] btn;
    int scans;
    logic [3:0] deb;
  } vec_t;
  vec_t tbl [6];
  debounce_scheduler #(.NUM_BTN(4), .HIST_LEN(8), .TICK_DIV(16)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .debounced(debounced),
    .scan_busy(scan_busy), .scan_done(scan_done), .pressed(pressed), .released(released)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if ($countones(pressed | released) > 1) multi++;
    for (int i = 0; i < 4; i++) begin
      if (pressed[i]) press_cnt[i]++;
      if (released[i]) rel_cnt[i]++;
    end
    if (!reset && dut.tick && scan_busy) ovr++;
  end
  function automatic logic [31:0] pcnt();
    return {8'(press_cnt[3]), 8'(press_cnt[2]), 8'(press_cnt[1]), 8'(press_cnt[0])};
  endfunction
  function automatic logic [31:0] rcnt();
    return {8'(rel_cnt[3]), 8'(rel_cnt[2]), 8'(rel_cnt[1]), 8'(rel_cnt[0])};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scan_done) return;
    end
    check("scan_done_timeout", 32'd1, 32'd0);
  endtask
  task automatic wait_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scan_busy) return;
    end
    check("scan_start_timeout", 32'd1, 32'd0);
  endtask
  task automatic settle();
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n;
    tbl[0] = '{4'b0000, 5, 4'b0000};
    tbl[1] = '{4'b0100, 7, 4'b0000};
    tbl[2] = '{4'b0101, 7, 4'b0100};
    tbl[3] = '{4'b0001, 1, 4'b0101};
    tbl[4] = '{4'b0001, 6, 4'b0101};
    tbl[5] = '{4'b0001, 1, 4'b0001};
    repeat (3) @(negedge clk);
    check("reset_outputs", {debounced, pressed, released, scan_busy, scan_done}, 0);
    reset = 1'b0;
    wait_start();
    for (int i = 0; i < 5; i++) begin
      check("frame_busy", scan_busy, 1);
      check("frame_done", scan_done, i == 4);
      @(negedge clk);
    end
    check("frame_busy_end", scan_busy, 0);
    n = 1;
    while (!scan_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scan_period", n, 16);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        wait_start();
        @(negedge clk);
        @(negedge clk);
        check("scan8_ch2_deb", debounced[2], 0);
        @(negedge clk);
        check("scan8_ch3_deb", debounced, 4'b0100);
        check("scan8_press", pressed, EDGE ? 4'b0100 : 4'b0000);
        @(negedge clk);
        check("scan8_done", scan_done, 1);
        check("scan8_press_end", pressed, 0);
      end
      buttons = tbl[i].btn;
      repeat (tbl[i].scans) wait_done();
      check($sformatf("table_row%0d", i), debounced, tbl[i].deb);
    end
    settle();
    check("table_press_cnt", pcnt(), EDGE ? 32'h00010001 : 32'h0);
    check("table_rel_cnt", rcnt(), EDGE ? 32'h00010000 : 32'h0);
    buttons = 4'h0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset2_deb", debounced, 0);
    for (int b = 0; b < 10; b++) begin
      buttons = (b % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (3) wait_done();
      check("toggle_deb", debounced, 0);
    end
    settle();
    check("toggle_press_cnt", pcnt(), EDGE ? 32'h00010001 : 32'h0);
    check("toggle_rel_cnt", rcnt(), EDGE ? 32'h00010000 : 32'h0);
    buttons = 4'b0010;
    n = 0;
    while (!debounced[1] && n < 20) begin
      wait_done();
      n++;
    end
    check("press_latency", n, 8);
    buttons = 4'b0000;
    repeat (7) wait_done();
    check("release_hold", debounced, 4'b0010);
    wait_done();
    check("release_fall", debounced, 0);
    settle();
    check("release_press_cnt", pcnt(), EDGE ? 32'h00010101 : 32'h0);
    check("release_rel_cnt", rcnt(), EDGE ? 32'h00010100 : 32'h0);
    buttons = 4'hF;
    repeat (8) wait_done();
    check("all_on_deb", debounced, 4'hF);
    wait_start();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midscan_reset", {debounced, pressed, released, scan_busy, scan_done}, 0);
    repeat (7) wait_done();
    check("post_reset_hold", debounced, 0);
    wait_done();
    check("post_reset_on", debounced, 4'hF);
    settle();
    check("final_press_cnt", pcnt(), EDGE ? 32'h02030303 : 32'h0);
    check("final_rel_cnt", rcnt(), EDGE ? 32'h00010100 : 32'h0);
    check("multi_pulse", multi, 0);
    check("overrun", ovr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
